// File: rtl/alu_issue_stage_if.sv
// Operand/handshake bundle between decode, the ID->EX issue register and the ALU.
// illegal_op exists only when ALU_ILLEGAL_OP_TRAP_EN is defined.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               alu_op;
    logic [2:0]               funct3;
    logic                     funct7_5;
    logic                     alu_src;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    logic                     illegal_op;
`endif

    // Decode/EX side: drives the instruction fields and consumes the issued operands.
    modport master (
        output in_valid, alu_op, funct3, funct7_5, alu_src,
               rs1_data, rs2_data, imm, flush, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation
`ifdef ALU_ILLEGAL_OP_TRAP_EN
        , input illegal_op
`endif
    );

    // Issue register side.
    modport slave (
        input  in_valid, alu_op, funct3, funct7_5, alu_src,
               rs1_data, rs2_data, imm, flush, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation
`ifdef ALU_ILLEGAL_OP_TRAP_EN
        , output illegal_op
`endif
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes ALUOp/funct3/funct7 into the ALU Operation code and registers
// SrcA/SrcB behind a one-entry valid/ready stage. Optional ALU_ILLEGAL_OP_TRAP_EN adds illegal_op.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_stage_if.slave  bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTI = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_BLT  = 4'b1010;
    localparam logic [3:0] OP_BGE  = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_BNE  = 4'b1110;

    logic [3:0]               dec_op;
    logic                     dec_illegal;
    logic                     dec_imm_shift;
    logic                     capture;
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0]    src_b_sel;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     illegal_q, illegal_d;

    always_comb begin
        dec_op        = OP_AND;
        dec_illegal   = 1'b0;
        dec_imm_shift = 1'b0;
        case (bus.alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                case (bus.funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (bus.funct3)
                    3'b000:  dec_op = bus.funct7_5 ? OP_SUB : OP_ADD;
                    3'b001:  dec_op = OP_SLL;
                    3'b010:  dec_op = OP_SLT;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = bus.funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (bus.funct3)
                    3'b000:  dec_op = OP_ADDI;
                    3'b001: begin
                        dec_op        = OP_SLL;
                        dec_imm_shift = 1'b1;
                    end
                    3'b010:  dec_op = OP_SLTI;
                    3'b100:  dec_op = OP_XOR;
                    3'b101: begin
                        dec_op        = bus.funct7_5 ? OP_SRA : OP_SRL;
                        dec_imm_shift = 1'b1;
                    end
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Immediate shifts only carry a 5-bit shamt; imm[10] is the SRAI flag and must not leak into SrcB.
    assign src_b_sel = bus.alu_src ? bus.imm : bus.rs2_data;

    always_comb begin
        src_a_d   = bus.rs1_data;
        src_b_d   = src_b_sel;
        if (dec_imm_shift) begin
            src_b_d = {{(DATA_WIDTH-5){1'b0}}, src_b_sel[4:0]};
        end
        op_d      = OPCODE_LENGTH'(dec_op);
        illegal_d = dec_illegal;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Data registers only load on capture, so a drained or flushed stage keeps showing its last operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                src_a_q   <= src_a_d;
                src_b_q   <= src_b_d;
                op_q      <= op_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.SrcA      = src_a_q;
    assign bus.SrcB      = src_b_q;
    assign bus.Operation = op_q;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
    assign bus.illegal_op = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table, handshake corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    alu_issue_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

    alu_issue_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  alu_op;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic        alu_src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  exp_op;
        logic [31:0] exp_b;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } ent_t;

    vec_t        vecs [16];
    logic [3:0]  ref_op    [64];
    logic        ref_legal [64];
    ent_t        model_q [$];
    ent_t        shown;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                input logic src, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [3:0] eop, input logic [31:0] eb,
                                input logic eill);
        vec_t v;
        v.alu_op = aop; v.funct3 = f3; v.funct7_5 = f7; v.alu_src = src;
        v.rs1 = r1; v.rs2 = r2; v.imm = im;
        v.exp_op = eop; v.exp_b = eb; v.exp_ill = eill;
        return v;
    endfunction

    // Reference decode table indexed by {alu_op, funct3, funct7_5}; unlisted encodings stay illegal.
    task automatic put(input int aop, input int f3, input int f7, input logic [3:0] code);
        for (int k = 0; k < 2; k++) begin
            if (f7 < 0 || f7 == k) begin
                ref_op[aop*16 + f3*2 + k]    = code;
                ref_legal[aop*16 + f3*2 + k] = 1'b1;
            end
        end
    endtask

    task automatic build_ref();
        for (int i = 0; i < 64; i++) begin
            ref_op[i] = 4'b0000;
            ref_legal[i] = 1'b0;
        end
        for (int f = 0; f < 8; f++) put(0, f, -1, 4'b0010);
        put(1, 0, -1, 4'b1000); put(1, 1, -1, 4'b1110);
        put(1, 4, -1, 4'b1010); put(1, 5, -1, 4'b1011);
        put(2, 0, 0, 4'b0010);  put(2, 0, 1, 4'b0110);
        put(2, 7, -1, 4'b0000); put(2, 6, -1, 4'b0001);
        put(2, 4, -1, 4'b0101); put(2, 2, -1, 4'b0111);
        put(2, 1, -1, 4'b1001); put(2, 5, 0, 4'b1101); put(2, 5, 1, 4'b0100);
        put(3, 0, -1, 4'b1100); put(3, 2, -1, 4'b0011);
        put(3, 7, -1, 4'b0000); put(3, 6, -1, 4'b0001);
        put(3, 4, -1, 4'b0101); put(3, 1, -1, 4'b1001);
        put(3, 5, 0, 4'b1101);  put(3, 5, 1, 4'b0100);
    endtask

    function automatic ent_t ref_issue(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                       input logic src, input logic [31:0] r1, input logic [31:0] r2,
                                       input logic [31:0] im);
        ent_t e;
        int   idx;
        idx   = int'(aop) * 16 + int'(f3) * 2 + int'(f7);
        e.a   = r1;
        e.b   = src ? im : r2;
        if (aop == 2'd3 && (f3 == 3'd1 || f3 == 3'd5)) e.b = e.b % 32;
        e.op  = ref_op[idx];
        e.ill = !ref_legal[idx];
        return e;
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [1:0] aop,
                         input logic [2:0] f3, input logic f7, input logic src,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        bus.in_valid = iv;  bus.out_ready = ordy; bus.flush = fl;
        bus.alu_op = aop;   bus.funct3 = f3;      bus.funct7_5 = f7;
        bus.alu_src = src;  bus.rs1_data = r1;    bus.rs2_data = r2; bus.imm = im;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input ent_t e);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".SrcA"}, bus.SrcA, e.a);
        chk({tag, ".SrcB"}, bus.SrcB, e.b);
        chk({tag, ".Operation"}, 32'(bus.Operation), 32'(e.op));
`ifdef ALU_ILLEGAL_OP_TRAP_EN
        chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'(e.ill));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t e, zero_e, held;
        logic exp_rdy, fire, consumed;
        logic iv, ordy, fl, f7, src;
        logic [1:0] aop;
        logic [2:0] f3;
        logic [31:0] r1, r2, im;

        tests_run = 0;
        tests_failed = 0;
        zero_e = '{a: 32'h0, b: 32'h0, op: 4'h0, ill: 1'b0};
        build_ref();

        reset = 1'b0;
        drive(0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check_outputs("reset", 1'b0, zero_e);
        reset = 1'b1;
        tick();
        chk("idle.in_ready", 32'(bus.in_ready), 32'd1);

        vecs[0]  = mk(2'b00, 3'b010, 0, 1, 32'd100, 32'd5, 32'hFFFF_FFFC, 4'b0010, 32'hFFFF_FFFC, 0);
        vecs[1]  = mk(2'b10, 3'b000, 1, 0, 32'd7, 32'd3, 32'h0, 4'b0110, 32'd3, 0);
        vecs[2]  = mk(2'b10, 3'b000, 0, 0, 32'd9, 32'd4, 32'h0, 4'b0010, 32'd4, 0);
        vecs[3]  = mk(2'b11, 3'b101, 1, 1, 32'd1, 32'd2, 32'h0000_0405, 4'b0100, 32'd5, 0);
        vecs[4]  = mk(2'b11, 3'b101, 0, 1, 32'd1, 32'd2, 32'hFFFF_FFE3, 4'b1101, 32'd3, 0);
        vecs[5]  = mk(2'b11, 3'b001, 0, 1, 32'd1, 32'd2, 32'h0000_001F, 4'b1001, 32'h1F, 0);
        vecs[6]  = mk(2'b11, 3'b000, 0, 1, 32'd1, 32'd2, 32'hFFFF_FF00, 4'b1100, 32'hFFFF_FF00, 0);
        vecs[7]  = mk(2'b01, 3'b001, 0, 0, 32'd1, 32'h0000_DEAD, 32'h5, 4'b1110, 32'h0000_DEAD, 0);
        vecs[8]  = mk(2'b01, 3'b010, 0, 0, 32'd2, 32'd8, 32'h5, 4'b0000, 32'd8, 1);
        vecs[9]  = mk(2'b10, 3'b011, 0, 0, 32'd3, 32'd9, 32'h5, 4'b0000, 32'd9, 1);
        vecs[10] = mk(2'b11, 3'b011, 0, 1, 32'd4, 32'd9, 32'h77, 4'b0000, 32'h77, 1);
        vecs[11] = mk(2'b10, 3'b101, 1, 0, 32'd5, 32'd31, 32'h0, 4'b0100, 32'd31, 0);
        vecs[12] = mk(2'b10, 3'b010, 0, 0, 32'd6, 32'd1, 32'h0, 4'b0111, 32'd1, 0);
        vecs[13] = mk(2'b11, 3'b010, 0, 1, 32'd6, 32'd1, 32'hFFFF_FFFF, 4'b0011, 32'hFFFF_FFFF, 0);
        vecs[14] = mk(2'b01, 3'b101, 0, 0, 32'd8, 32'd2, 32'h0, 4'b1011, 32'd2, 0);
        vecs[15] = mk(2'b10, 3'b110, 0, 0, 32'hA5A5_0000, 32'h0F0F, 32'h0, 4'b0001, 32'h0F0F, 0);

        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, vecs[i].alu_op, vecs[i].funct3, vecs[i].funct7_5, vecs[i].alu_src,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick();
            e = '{a: vecs[i].rs1, b: vecs[i].exp_b, op: vecs[i].exp_op, ill: vecs[i].exp_ill};
            check_outputs($sformatf("vec%0d", i), 1'b1, e);
        end
        drive(0, 1, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
        tick();
        chk("drain.out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain.SrcA_held", bus.SrcA, vecs[15].rs1);

        // Stall: a held entry must survive three cycles of backpressure.
        drive(1, 0, 0, 2'b10, 3'b100, 0, 0, 32'd11, 32'd22, 0);
        tick();
        held = '{a: 32'd11, b: 32'd22, op: 4'b0101, ill: 1'b0};
        check_outputs("stall.cap", 1'b1, held);
        drive(1, 0, 0, 2'b10, 3'b111, 0, 0, 32'd33, 32'd44, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("stall%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
            tick();
            check_outputs($sformatf("stall%0d", c), 1'b1, held);
        end
        bus.out_ready = 1'b1;
        #2;
        chk("unstall.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_outputs("unstall", 1'b1, '{a: 32'd33, b: 32'd44, op: 4'b0000, ill: 1'b0});
        drive(0, 1, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
        tick();
        chk("unstall.drain", 32'(bus.out_valid), 32'd0);

        // Flush kills the held entry and the one offered alongside it.
        drive(1, 0, 0, 2'b00, 3'b000, 0, 0, 32'd55, 32'd1, 0);
        tick();
        chk("flush.pre_valid", 32'(bus.out_valid), 32'd1);
        drive(1, 1, 1, 2'b10, 3'b100, 0, 0, 32'd66, 32'd2, 0);
        tick();
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.SrcA_kept", bus.SrcA, 32'd55);
        drive(0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
        tick();
        chk("flush.stays_idle", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a pending transfer.
        drive(1, 0, 0, 2'b10, 3'b000, 1, 0, 32'd77, 32'd88, 0);
        tick();
        chk("rstmid.pre_valid", 32'(bus.out_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_outputs("rstmid", 1'b0, zero_e);
        drive(0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();

        model_q.delete();
        shown = zero_e;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 99) < 8);
            aop  = 2'($urandom_range(0, 3));
            f3   = 3'($urandom_range(0, 7));
            f7   = 1'($urandom_range(0, 1));
            src  = 1'($urandom_range(0, 1));
            r1   = $urandom;
            r2   = $urandom;
            im   = $urandom;
            drive(iv, ordy, fl, aop, f3, f7, src, r1, r2, im);
            #2;
            exp_rdy = (model_q.size() == 0) || ordy;
            chk("rand.in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            fire     = iv && exp_rdy && !fl;
            consumed = (model_q.size() != 0) && ordy;
            tick();
            if (fl) begin
                model_q.delete();
            end else begin
                if (consumed) void'(model_q.pop_front());
                if (fire) begin
                    e = ref_issue(aop, f3, f7, src, r1, r2, im);
                    model_q.push_back(e);
                    shown = e;
                end
            end
            check_outputs("rand", model_q.size() != 0, shown);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
